// File: rtl/seven_segment_scan_decoder_if.sv
// Display bus between a multiplexed 7-segment driver and the scan decoder.
// The master drives seg/dig_sel; the slave (decoder) returns the recovered digits.
interface seven_segment_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   dig_sel;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    frame_valid;
   logic                    frame_err;

   modport master (
      output seg, dig_sel,
      input  digits, digit_err, frame_valid, frame_err
   );

   modport slave (
      input  seg, dig_sel,
      output digits, digit_err, frame_valid, frame_err
   );
endinterface

// File: rtl/seven_segment_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment bus: each one-hot digit pattern is
// captured once it has been stable long enough, and complete scans are flagged as frames.
module seven_segment_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input logic clk,
   input logic rst,
   seven_segment_scan_decoder_if.slave bus
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]         CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]         CNT_ONE = CW'(1);
   localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

   logic [6:0]              prev_seg_reg;
   logic [NUM_DIGITS-1:0]   prev_sel_reg;
   logic [CW-1:0]           cnt_reg, cnt_next;
   logic                    armed_reg, armed_next, armed_eff;
   logic [NUM_DIGITS-1:0]   seen_reg, seen_next;
   logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
   logic [NUM_DIGITS-1:0]   digit_err_reg, digit_err_next;
   logic                    frame_valid_reg, frame_err_reg;

   logic                    one_hot, same_pair, capture, frame_done;
   logic [NUM_DIGITS-1:0]   cap_vec;
   logic [3:0]              dec_val;
   logic                    dec_err;

   assign one_hot   = (bus.dig_sel != '0) && ((bus.dig_sel & (bus.dig_sel - SEL_ONE)) == '0);
   assign same_pair = one_hot && (bus.seg == prev_seg_reg) && (bus.dig_sel == prev_sel_reg);

   // A changed pair re-arms immediately, so STABLE_CYCLES=1 captures on its first edge.
   always_comb begin
      armed_eff = same_pair ? armed_reg : 1'b1;
      if (!one_hot)
         cnt_next = '0;
      else if (!same_pair)
         cnt_next = CNT_ONE;
      else if (cnt_reg < CNT_MAX)
         cnt_next = cnt_reg + CNT_ONE;
      else
         cnt_next = CNT_MAX;
   end

   assign capture    = one_hot && (cnt_next == CNT_MAX) && armed_eff;
   assign armed_next = capture ? 1'b0 : (one_hot ? armed_eff : 1'b1);

   always_comb begin
      dec_val = 4'h0;
      dec_err = 1'b0;
      case (bus.seg)
         7'h40: dec_val = 4'h0;
         7'h79: dec_val = 4'h1;
         7'h24: dec_val = 4'h2;
         7'h30: dec_val = 4'h3;
         7'h19: dec_val = 4'h4;
         7'h12: dec_val = 4'h5;
         7'h02: dec_val = 4'h6;
         7'h78: dec_val = 4'h7;
         7'h00: dec_val = 4'h8;
         7'h10: dec_val = 4'h9;
         7'h08: dec_val = 4'hA;
         7'h03: dec_val = 4'hB;
         7'h46: dec_val = 4'hC;
         7'h21: dec_val = 4'hD;
         7'h06: dec_val = 4'hE;
         7'h0e: dec_val = 4'hF;
         default: begin
            dec_val = 4'h0;
            dec_err = 1'b1;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign cap_vec[gi]               = capture & bus.dig_sel[gi];
         assign digits_next[4*gi +: 4]    = cap_vec[gi] ? dec_val : digits_reg[4*gi +: 4];
         assign digit_err_next[gi]        = cap_vec[gi] ? dec_err : digit_err_reg[gi];
      end
   endgenerate

   assign seen_next  = seen_reg | cap_vec;
   assign frame_done = capture && (&seen_next);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_seg_reg    <= 7'h7f;
         prev_sel_reg    <= '0;
         cnt_reg         <= '0;
         armed_reg       <= 1'b1;
         seen_reg        <= '0;
         digits_reg      <= '0;
         digit_err_reg   <= '0;
         frame_valid_reg <= 1'b0;
         frame_err_reg   <= 1'b0;
      end else begin
         prev_seg_reg  <= bus.seg;
         prev_sel_reg  <= bus.dig_sel;
         cnt_reg       <= cnt_next;
         armed_reg     <= armed_next;
         digits_reg    <= digits_next;
         digit_err_reg <= digit_err_next;
         if (frame_done) begin
            seen_reg        <= '0;
            frame_valid_reg <= 1'b1;
            frame_err_reg   <= |digit_err_next;
         end else begin
            seen_reg        <= seen_next;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
         end
      end
   end

   assign bus.digits      = digits_reg;
   assign bus.digit_err   = digit_err_reg;
   assign bus.frame_valid = frame_valid_reg;
   assign bus.frame_err   = frame_err_reg;
endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for the 7-segment scan decoder: a vector table of scan steps plus
// hand-written reset, latency, decode-table and partial-frame sequences.
module tb_seven_segment_scan_decoder;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seven_segment_scan_decoder_if #(.NUM_DIGITS(N)) bus ();

   seven_segment_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [6:0]  seg;
      logic [3:0]  sel;
      int          hold;
      logic [15:0] exp_dig;
      logic [3:0]  exp_err;
      int          exp_fv;
      logic        exp_fe;
   } vec_t;

   vec_t vecs[16];
   logic [6:0] codes[16];

   int   total = 0;
   int   bad   = 0;
   int   fv_cnt;
   logic fe_seen;
   logic fe_stray;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] s, input logic [3:0] d);
      bus.seg     = s;
      bus.dig_sel = d;
   endtask

   // Advance n edges, sampling 1 time unit after each one.
   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bus.frame_valid === 1'b1) begin
            fv_cnt++;
            fe_seen = bus.frame_err;
         end else if (bus.frame_err !== 1'b0) begin
            fe_stray = 1'b1;
         end
      end
   endtask

   initial begin
      codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

      // scan "1A3F"
      vecs[0]  = '{7'h79, 4'b0001, 4,  16'h0001, 4'b0000, 0, 1'b0};
      vecs[1]  = '{7'h08, 4'b0010, 4,  16'h00A1, 4'b0000, 0, 1'b0};
      vecs[2]  = '{7'h30, 4'b0100, 4,  16'h03A1, 4'b0000, 0, 1'b0};
      vecs[3]  = '{7'h0e, 4'b1000, 4,  16'hF3A1, 4'b0000, 1, 1'b0};
      // glitch: 3 cycles of 0 then 8
      vecs[4]  = '{7'h40, 4'b0001, 3,  16'hF3A1, 4'b0000, 0, 1'b0};
      vecs[5]  = '{7'h00, 4'b0001, 4,  16'hF3A8, 4'b0000, 0, 1'b0};
      // blank on digit 2
      vecs[6]  = '{7'h19, 4'b0001, 4,  16'hF3A4, 4'b0000, 0, 1'b0};
      vecs[7]  = '{7'h12, 4'b0010, 4,  16'hF354, 4'b0000, 0, 1'b0};
      vecs[8]  = '{7'h7f, 4'b0100, 4,  16'hF054, 4'b0100, 0, 1'b0};
      vecs[9]  = '{7'h06, 4'b1000, 4,  16'hE054, 4'b0100, 1, 1'b1};
      // select faults, then a long dwell
      vecs[10] = '{7'h00, 4'b0000, 10, 16'hE054, 4'b0100, 0, 1'b0};
      vecs[11] = '{7'h40, 4'b0011, 10, 16'hE054, 4'b0100, 0, 1'b0};
      vecs[12] = '{7'h46, 4'b0010, 20, 16'hE0C4, 4'b0100, 0, 1'b0};
      vecs[13] = '{7'h21, 4'b0001, 4,  16'hE0CD, 4'b0100, 0, 1'b0};
      vecs[14] = '{7'h03, 4'b0100, 4,  16'hEBCD, 4'b0000, 0, 1'b0};
      vecs[15] = '{7'h02, 4'b1000, 4,  16'h6BCD, 4'b0000, 1, 1'b0};

      rst = 1'b1;
      drive(7'h7f, 4'b0000);
      #12;
      check("reset_digits", 32'(bus.digits), 32'h0);
      check("reset_err",    32'(bus.digit_err), 32'h0);
      check("reset_fv",     32'(bus.frame_valid), 32'h0);
      check("reset_fe",     32'(bus.frame_err), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         fv_cnt   = 0;
         fe_seen  = 1'b0;
         fe_stray = 1'b0;
         drive(vecs[i].seg, vecs[i].sel);
         hold(vecs[i].hold);
         $display("vec %0d seg=%h sel=%b digits=%h err=%b frames=%0d fe=%b",
                  i, vecs[i].seg, vecs[i].sel, bus.digits, bus.digit_err, fv_cnt, fe_seen);
         check($sformatf("vec%0d_digits", i), 32'(bus.digits), 32'(vecs[i].exp_dig));
         check($sformatf("vec%0d_err", i),    32'(bus.digit_err), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_frames", i), 32'(fv_cnt), 32'(vecs[i].exp_fv));
         check($sformatf("vec%0d_stray_fe", i), 32'(fe_stray), 32'h0);
         if (vecs[i].exp_fv != 0)
            check($sformatf("vec%0d_frame_err", i), 32'(fe_seen), 32'(vecs[i].exp_fe));
      end

      // full decode table on digit 0; only digit 0 is seen, so no frame
      fv_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         drive(codes[i], 4'b0001);
         hold(4);
         $display("table %0d seg=%h digit0=%h err0=%b", i, codes[i], bus.digits[3:0], bus.digit_err[0]);
         check($sformatf("table%0d_val", i), 32'(bus.digits[3:0]), 32'(i));
         check($sformatf("table%0d_err", i), 32'(bus.digit_err[0]), 32'h0);
      end
      check("table_frames", 32'(fv_cnt), 32'h0);

      // async reset mid-dwell, then latency after release
      drive(7'h79, 4'b0100);
      hold(2);
      #2;
      rst = 1'b1;
      #1;
      $display("async reset: digits=%h err=%b fv=%b", bus.digits, bus.digit_err, bus.frame_valid);
      check("areset_digits", 32'(bus.digits), 32'h0);
      check("areset_err",    32'(bus.digit_err), 32'h0);
      check("areset_fv",     32'(bus.frame_valid), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold(3);
      check("latency_early", 32'(bus.digits), 32'h0);
      hold(1);
      $display("latency: digits=%h after 4 edges", bus.digits);
      check("latency_capture", 32'(bus.digits), 32'h0100);

      // partial frame discarded by reset
      fv_cnt = 0;
      drive(7'h40, 4'b0001); hold(4);
      drive(7'h79, 4'b0010); hold(4);
      drive(7'h24, 4'b0100); hold(4);
      rst = 1'b1;
      #3;
      rst = 1'b0;
      drive(7'h06, 4'b1000); hold(4);
      drive(7'h7f, 4'b0000); hold(4);
      $display("partial+reset: digits=%h frames=%0d", bus.digits, fv_cnt);
      check("partial_frames", 32'(fv_cnt), 32'h0);
      check("partial_digits", 32'(bus.digits), 32'hE000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
